// File: rtl/watch_time_ctrl.sv
// Watch timekeeping core: synchronised second tick, debounced mode/inc buttons,
// BCD hh:mm:ss counters and a RUN / SET_H / SET_M setting FSM.

module watch_debounce #(
    parameter int unsigned CYCLES = 327
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);
    localparam int unsigned CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic          s1_q, s2_q;
    logic          armed_q, armed_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // armed_q=1 waits for a stable high (press); armed_q=0 waits for a stable low (re-arm).
    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        press_o = 1'b0;
        if (s2_q == armed_q) begin
            if (cnt_q == LAST) begin
                cnt_d   = '0;
                armed_d = !armed_q;
                press_o = armed_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            armed_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= btn_i;
            s2_q    <= s1_q;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

module watch_time_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 327
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sec_clk_i,
    input  logic       btn_mode_i,
    input  logic       btn_inc_i,
    output logic [7:0] hours_o,
    output logic [7:0] minutes_o,
    output logic [7:0] seconds_o,
    output logic [1:0] mode_o,
    output logic       blink_o
);
    typedef enum logic [1:0] {
        RUN   = 2'b00,
        SET_H = 2'b01,
        SET_M = 2'b10
    } mode_e;

    mode_e      state_q, state_d;
    logic [7:0] hours_q, hours_d;
    logic [7:0] minutes_q, minutes_d;
    logic [7:0] seconds_q, seconds_d;
    logic       blink_q, blink_d;
    logic       sec_s1_q, sec_s2_q, sec_prev_q;
    logic       tick;
    logic       mode_press, inc_press;
    logic [8:0] sec_inc, min_inc, hr_inc;

    // Returns {wrapped, next}; wrapped is set when v was already at max_v.
    function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        logic [8:0] r;
        if (v == max_v) begin
            r = 9'h100;
        end else if (v[3:0] == 4'd9) begin
            r = {1'b0, v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {1'b0, v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    watch_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .btn_i   (btn_mode_i),
        .press_o (mode_press)
    );

    watch_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .btn_i   (btn_inc_i),
        .press_o (inc_press)
    );

    assign tick    = sec_s2_q ^ sec_prev_q;
    assign sec_inc = bcd_inc(seconds_q, 8'h59);
    assign min_inc = bcd_inc(minutes_q, 8'h59);
    assign hr_inc  = bcd_inc(hours_q, 8'h23);

    always_comb begin
        state_d   = state_q;
        hours_d   = hours_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;
        blink_d   = blink_q;
        case (state_q)
            RUN: begin
                blink_d = 1'b0;
                if (tick) begin
                    seconds_d = sec_inc[7:0];
                    if (sec_inc[8]) begin
                        minutes_d = min_inc[7:0];
                        if (min_inc[8]) hours_d = hr_inc[7:0];
                    end
                end
                if (mode_press) begin
                    state_d = SET_H;
                    blink_d = 1'b1;
                end
            end
            SET_H: begin
                if (mode_press) begin
                    state_d = SET_M;
                    blink_d = 1'b1;
                end else begin
                    if (inc_press) hours_d = hr_inc[7:0];
                    if (tick) blink_d = !blink_q;
                end
            end
            SET_M: begin
                if (mode_press) begin
                    state_d   = RUN;
                    seconds_d = 8'h00;
                    blink_d   = 1'b0;
                end else begin
                    if (inc_press) minutes_d = min_inc[7:0];
                    if (tick) blink_d = !blink_q;
                end
            end
            default: begin
                state_d = RUN;
                blink_d = 1'b0;
            end
        endcase
    end

    // The second-clock path resets high to match the divider, so no tick follows reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            hours_q    <= 8'h00;
            minutes_q  <= 8'h00;
            seconds_q  <= 8'h00;
            blink_q    <= 1'b0;
            sec_s1_q   <= 1'b1;
            sec_s2_q   <= 1'b1;
            sec_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            hours_q    <= hours_d;
            minutes_q  <= minutes_d;
            seconds_q  <= seconds_d;
            blink_q    <= blink_d;
            sec_s1_q   <= sec_clk_i;
            sec_s2_q   <= sec_s1_q;
            sec_prev_q <= sec_s2_q;
        end
    end

    assign hours_o   = hours_q;
    assign minutes_o = minutes_q;
    assign seconds_o = seconds_q;
    assign mode_o    = state_q;
    assign blink_o   = blink_q;
endmodule
